p405s_gpr_wb_addr_pipe: RTL
===========================

P405S_GPR_WB_ADDR_PIPE -- requirements
Module: p405s_gpr_wb_addr_pipe

Interface
REQ-001 CB  input  1  core clock; all state updates on its rising edge.
REQ-002 resetCore  input  1  reset, asynchronous, active-high.
REQ-003 exeFull  input  1  exe stage holds a valid instruction.
REQ-004 exeLpAddr  input  [0:4]  load-port (Lp) GPR target of the exe instruction.
REQ-005 exeLpWrEn  input  1  exe instruction writes GPR through Lp (load).
REQ-006 exeRpAddr  input  [0:4]  result-port (Rp) GPR target of the exe instruction.
REQ-007 exeRpWrEn  input  1  exe instruction writes GPR through Rp.
REQ-008 exeAdvance  input  1  exe instruction moves to wb this cycle.
REQ-009 wbFlush  input  1  kill the wb-stage instruction.
REQ-010 lwbLoadDone  input  1  load data for the lwb entry returns this cycle.
REQ-011 wbLpAddr  output  [0:4]  wb-stage Lp address.
REQ-012 PCL_wbRpAddr  output  [0:4]  wb-stage Rp address.
REQ-013 wbFullL2  output  1  wb stage valid.
REQ-014 wbRpWrEn  output  1  Rp GPR write this cycle: wbFullL2 & wbRpVal.
REQ-015 PCL_lwbLpAddr  output  [0:4]  pending-load Lp address.
REQ-016 lwbFullL2  output  1  load pending in lwb.
REQ-017 lwbLpAddr_NEG  output  [0:4]  bitwise inverse of PCL_lwbLpAddr.
REQ-018 wbRpAddr_NEG  output  [0:4]  bitwise inverse of PCL_wbRpAddr.
REQ-019 exeHold  output  1  wb cannot accept; upstream shall not advance.
REQ-020 lwbWaitCnt  output  [0:3]  cycles the current load has been pending.

Function
REQ-021 wbHold = wbFullL2 & wbLpVal & lwbFullL2 & ~lwbLoadDone (combinational); exeHold = wbHold.
REQ-022 wb leaves ("wbDone") when wbFullL2 & ~wbHold & ~wbFlush.
REQ-023 wb load: on exeAdvance & exeFull & ~wbHold, the wb registers capture exeLpAddr, exeRpAddr, exeLpWrEn, exeRpWrEn; wbFullL2 <= 1.
REQ-024 If there is no load and wbDone is true, or wbFlush is asserted, wbFullL2 <= 0; the address registers hold their values.
REQ-025 If wbFlush and an exe load occur in the same cycle, the load wins: the flush kills the old entry only.
REQ-026 exeAdvance while exeHold is asserted is ignored: wb is unchanged and nothing is lost or duplicated.
REQ-027 The lwb FSM has two states, EMPTY and PEND; lwbFullL2 = (state == PEND).
REQ-028 EMPTY->PEND when wbDone & wbLpVal; PCL_lwbLpAddr <= wbLpAddr.
REQ-029 PEND->EMPTY on lwbLoadDone, unless wbDone & wbLpVal occurs in the same cycle; in that case the FSM stays PEND and captures the new address.
REQ-030 A wb entry with Lp valid and Rp invalid does not produce wbRpWrEn.
REQ-031 lwbWaitCnt is cleared to 0 on entry to PEND (including a re-entry under REQ-029), increments each PEND cycle, saturates at 15, and is 0 in EMPTY.
REQ-032 Latency: an exe address is visible on wb outputs 1 cycle after exeAdvance, and on lwb outputs 1 cycle after wbDone.
REQ-033 The _NEG outputs are combinational inversions of the registered addresses: no extra latency.

Reset
REQ-034 While resetCore is asserted: wbFullL2=0, lwbFullL2=0 (EMPTY), wbRpWrEn=0, exeHold=0, lwbWaitCnt=0, all addresses 0, all _NEG outputs 5'b11111.
REQ-035 Reset asserted mid-load discards the pending load; lwbLoadDone arriving after reset is ignored while in EMPTY.

Structure
REQ-036 The lwb state encoding (EMPTY=0, PEND=1) and the counter saturation value 15 are defined in the shared p405s package.
REQ-037 The lwb FSM plus lwbWaitCnt form one sub-module, p405s_lwbLoadTrk; wb registers and hold logic stay at top level.

Verification
REQ-038 Rp-only: exeRpAddr=5, exeRpWrEn=1, exeAdvance -> next cycle PCL_wbRpAddr=5, wbRpWrEn=1, wbRpAddr_NEG=5'b11010; the following cycle wbFullL2=0.
REQ-039 Load then stall: load to r7 reaches lwb; second load to r9 in wb with lwbLoadDone=0 for 3 cycles -> exeHold=1 for those 3 cycles, lwbWaitCnt counts 0,1,2,3; lwbLoadDone -> next cycle PCL_lwbLpAddr=9, lwbWaitCnt=0.
REQ-040 Simultaneous events: lwbLoadDone coincides with wbDone of a load to r3 -> lwbFullL2 stays 1, PCL_lwbLpAddr=3.
REQ-041 Saturation: load pending for 20 cycles -> lwbWaitCnt reaches 15 and holds at 15.
REQ-042 Flush/reset: wbFlush with a wb load to r4 -> lwb stays EMPTY; resetCore asserted during PEND -> all outputs take their REQ-034 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/p405s_gpr_wb_addr_pipe_pkg.sv
// Shared definitions for the GPR writeback address pipe: lwb tracker
// state encoding and wait-counter saturation limit.
package p405s_gpr_wb_addr_pipe_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    PEND  = 1'b1
  } lwbState_e;

  localparam logic [3:0] lwbCntSat = 4'd15;

endpackage

// File: rtl/p405s_gpr_wb_addr_pipe_if.sv
// Exe/wb/lwb signal bundle for the GPR writeback address pipe; the slave
// modport is the pipe itself, the master modport is whoever drives exe.
interface p405s_gpr_wb_addr_pipe_if;

  logic       exeFull;
  logic [0:4] exeLpAddr;
  logic       exeLpWrEn;
  logic [0:4] exeRpAddr;
  logic       exeRpWrEn;
  logic       exeAdvance;
  logic       wbFlush;
  logic       lwbLoadDone;

  logic [0:4] wbLpAddr;
  logic [0:4] PCL_wbRpAddr;
  logic       wbFullL2;
  logic       wbRpWrEn;
  logic [0:4] PCL_lwbLpAddr;
  logic       lwbFullL2;
  logic [0:4] lwbLpAddr_NEG;
  logic [0:4] wbRpAddr_NEG;
  logic       exeHold;
  logic [0:3] lwbWaitCnt;

  modport master (
    output exeFull, exeLpAddr, exeLpWrEn, exeRpAddr, exeRpWrEn, exeAdvance,
    output wbFlush, lwbLoadDone,
    input  wbLpAddr, PCL_wbRpAddr, wbFullL2, wbRpWrEn, PCL_lwbLpAddr,
    input  lwbFullL2, lwbLpAddr_NEG, wbRpAddr_NEG, exeHold, lwbWaitCnt
  );

  modport slave (
    input  exeFull, exeLpAddr, exeLpWrEn, exeRpAddr, exeRpWrEn, exeAdvance,
    input  wbFlush, lwbLoadDone,
    output wbLpAddr, PCL_wbRpAddr, wbFullL2, wbRpWrEn, PCL_lwbLpAddr,
    output lwbFullL2, lwbLpAddr_NEG, wbRpAddr_NEG, exeHold, lwbWaitCnt
  );

endinterface

// File: rtl/p405s_gpr_wb_addr_pipe_lwbLoadTrk.sv
// Pending-load tracker: remembers the Lp target of the one outstanding load
// and counts how long it has been waiting for its data.
module p405s_lwbLoadTrk
  import p405s_gpr_wb_addr_pipe_pkg::*;
(
  input  logic       CB,
  input  logic       resetCore,
  input  logic       lwbCapture,
  input  logic [0:4] captureAddr,
  input  logic       lwbLoadDone,
  output logic       lwbFull,
  output logic [0:4] lwbAddr,
  output logic [0:3] waitCnt
);

  lwbState_e state;

  // A new load arriving in the same cycle the old one completes keeps us in
  // PEND but restarts the wait count for the new address.
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      state   <= EMPTY;
      lwbAddr <= '0;
      waitCnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (lwbCapture) begin
            state   <= PEND;
            lwbAddr <= captureAddr;
            waitCnt <= '0;
          end
        end
        PEND: begin
          if (lwbCapture) begin
            lwbAddr <= captureAddr;
            waitCnt <= '0;
          end else if (lwbLoadDone) begin
            state   <= EMPTY;
            waitCnt <= '0;
          end else if (waitCnt != lwbCntSat) begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        default: begin
          state   <= EMPTY;
          waitCnt <= '0;
        end
      endcase
    end
  end

  assign lwbFull = (state == PEND);

endmodule

// File: rtl/p405s_gpr_wb_addr_pipe.sv
// GPR writeback address pipe: wb-stage address registers, wb hold logic and
// the pending-load (lwb) tracker.
module p405s_gpr_wb_addr_pipe
  import p405s_gpr_wb_addr_pipe_pkg::*;
(
  input  logic                          CB,
  input  logic                          resetCore,
  p405s_gpr_wb_addr_pipe_if.slave       bus
);

  logic       wbFull;
  logic [0:4] wbLpAddrQ;
  logic [0:4] wbRpAddrQ;
  logic       wbLpVal;
  logic       wbRpVal;
  logic       wbHold;
  logic       wbDone;
  logic       wbLoad;
  logic       lwbFull;
  logic [0:4] lwbAddr;
  logic [0:3] lwbCnt;

  // A second load cannot leave wb while the previous one still owns lwb.
  assign wbHold = wbFull & wbLpVal & lwbFull & ~bus.lwbLoadDone;
  assign wbDone = wbFull & ~wbHold & ~bus.wbFlush;
  assign wbLoad = bus.exeAdvance & bus.exeFull & ~wbHold;

  // A fresh load takes priority over a flush, which only kills the old entry.
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      wbFull    <= 1'b0;
      wbLpAddrQ <= '0;
      wbRpAddrQ <= '0;
      wbLpVal   <= 1'b0;
      wbRpVal   <= 1'b0;
    end else if (wbLoad) begin
      wbFull    <= 1'b1;
      wbLpAddrQ <= bus.exeLpAddr;
      wbRpAddrQ <= bus.exeRpAddr;
      wbLpVal   <= bus.exeLpWrEn;
      wbRpVal   <= bus.exeRpWrEn;
    end else if (wbDone || bus.wbFlush) begin
      wbFull    <= 1'b0;
    end
  end

  p405s_lwbLoadTrk uLwbLoadTrk (
    .CB          (CB),
    .resetCore   (resetCore),
    .lwbCapture  (wbDone & wbLpVal),
    .captureAddr (wbLpAddrQ),
    .lwbLoadDone (bus.lwbLoadDone),
    .lwbFull     (lwbFull),
    .lwbAddr     (lwbAddr),
    .waitCnt     (lwbCnt)
  );

  assign bus.wbLpAddr      = wbLpAddrQ;
  assign bus.PCL_wbRpAddr  = wbRpAddrQ;
  assign bus.wbFullL2      = wbFull;
  assign bus.wbRpWrEn      = wbFull & wbRpVal;
  assign bus.PCL_lwbLpAddr = lwbAddr;
  assign bus.lwbFullL2     = lwbFull;
  assign bus.lwbLpAddr_NEG = ~lwbAddr;
  assign bus.wbRpAddr_NEG  = ~wbRpAddrQ;
  assign bus.exeHold       = wbHold;
  assign bus.lwbWaitCnt    = lwbCnt;

endmodule
